// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - request/result handshake and shared 4-bit adder bus
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  // Requester side
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  // External combinational 4-bit adder side
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  // The environment: requesting datapath plus the adder instance
  modport master (
    output start, op_a, op_b, cin, add_sum, add_cout,
    input  busy, done, result, cout, add_a, add_b, add_cin
  );

  // The sequencer
  modport slave (
    input  start, op_a, op_b, cin, add_sum, add_cout,
    output busy, done, result, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequenced through one shared 4-bit adder
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  logic             accept;
  logic             last_pass;

  // A request is taken only from IDLE; RUN/DONE ignore start (no queueing)
  assign accept    = (state == S_IDLE) && bus.start;
  assign last_pass = (state == S_RUN) && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> RUN on accept, RUN -> DONE after the top nibble, DONE -> IDLE always
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then write one sum nibble per RUN cycle and chain the carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.op_a;
      b_q   <= bus.op_b;
      carry <= bus.cin;
      idx   <= '0;
    end else if (state == S_RUN) begin
      result_q[{idx, 2'b00} +: 4] <= bus.add_sum;
      carry                       <= bus.add_cout;
      if (last_pass) begin
        // Park idx at 0 so it never steps past the top nibble for non-power-of-2 NIBBLES
        cout_q <= bus.add_cout;
        idx    <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Outputs: status decode and adder drive, adder inputs held at 0 outside RUN
  always_comb begin
    bus.busy    = (state != S_IDLE);
    bus.done    = (state == S_DONE);
    bus.result  = result_q;
    bus.cout    = cout_q;
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state == S_RUN) begin
      bus.add_a   = a_q[{idx, 2'b00} +: 4];
      bus.add_b   = b_q[{idx, 2'b00} +: 4];
      bus.add_cin = carry;
    end
  end

endmodule
